vec_stream_tx: RTL and testbench
================================

VEC_STREAM_TX -- requirements
Module: vec_stream_tx

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits, signed two's complement.
REQ-002 Parameter LENX, default 8: samples per vector.
REQ-003 Parameter LOGLEN, default 3: index width, ceil(log2(LENX)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 ld_data  input  WIDTH  sample to load into the vector buffer.
REQ-007 ld_valid  input  1  ld_data is valid.
REQ-008 ld_ready  output  1  buffer accepts a sample this cycle.
REQ-009 start  input  1  request to stream the loaded vector.
REQ-010 clr  input  1  discard the buffer and return to loading.
REQ-011 m_data_out_x  output  WIDTH  streamed sample, signed.
REQ-012 m_valid_x  output  1  m_data_out_x is valid.
REQ-013 m_ready_x  input  1  downstream consumer (s_ready_x of a conv layer) accepts.
REQ-014 busy  output  1  high in SEND state.
REQ-015 vec_count  output  8  number of completed vector transmissions, modulo 256.

Function
REQ-016 FSM states SHALL be LOAD, FULL and SEND, with internal counters ld_idx and tx_idx (LOGLEN bits each) and a LENX x WIDTH register buffer.
REQ-017 LOAD: ld_ready=1; a load transfer (ld_valid & ld_ready) SHALL write buffer[ld_idx] and increment ld_idx; the transfer at ld_idx==LENX-1 SHALL set ld_idx=0 and move to FULL.
REQ-018 FULL: ld_ready=0, m_valid_x=0; start=1 SHALL move to SEND with tx_idx=0.
REQ-019 SEND: m_valid_x=1 and m_data_out_x=buffer[tx_idx]; a transfer (m_valid_x & m_ready_x) SHALL increment tx_idx.
REQ-020 A transfer at tx_idx==LENX-1 SHALL increment vec_count (255 wraps to 0), clear tx_idx and move to FULL (see REQ-029).
REQ-021 While m_valid_x=1 and m_ready_x=0, m_data_out_x and m_valid_x SHALL hold unchanged; m_valid_x SHALL NOT drop before a transfer except through clr or reset.
REQ-022 Latency: start high in FULL at edge N SHALL give m_valid_x=1 with buffer[0] from cycle N+1; with m_ready_x held high, LENX transfers SHALL occur on consecutive cycles.
REQ-023 start SHALL be ignored in LOAD and SEND; ld_valid SHALL be ignored outside LOAD.
REQ-024 clr SHALL take priority over every other input: next state LOAD, ld_idx=0, tx_idx=0, m_valid_x=0 the next cycle; buffer contents need not be cleared; vec_count is unaffected.
REQ-025 clr during SEND SHALL abort the vector without incrementing vec_count, even when a transfer occurs in the same cycle.
REQ-026 The buffer SHALL be retained in FULL so the same vector can be re-sent by asserting start again.

Reset
REQ-027 reset SHALL have priority over clr and override any operation in progress, including mid-LOAD and mid-SEND.
REQ-028 Values on the cycle after reset: state=LOAD, ld_idx=0, tx_idx=0, ld_ready=1, m_valid_x=0, m_data_out_x=0, busy=0, vec_count=0.

Configuration
REQ-029 Macro VEC_TX_LOOP_EN: when defined, start=1 together with the final SEND transfer SHALL keep the FSM in SEND, with buffer[0] valid on the next cycle (no bubble) and vec_count still incremented. When undefined, the final transfer always moves to FULL, giving at least one cycle with m_valid_x=0 between vectors.

Verification
REQ-030 Reset, load 1,2,...,8 with ld_valid held high, pulse start, m_ready_x=1 -> ld_ready low after 8 loads; outputs 1..8 on 8 consecutive cycles; vec_count=1; busy falls after the 8th transfer.
REQ-031 Backpressure: during SEND, drop m_ready_x for 3 cycles at tx_idx=2 -> m_data_out_x=3 and m_valid_x=1 held for all 3 cycles; no sample is lost or duplicated.
REQ-032 Loaded vector -5,7,0,-128,127,1,-1,2 -> signed values are transmitted bit-exact; a second start re-sends an identical sequence and vec_count=2.
REQ-033 clr asserted together with a transfer at tx_idx=4 -> m_valid_x=0 next cycle, state LOAD, ld_ready=1, vec_count unchanged.
REQ-034 start held high continuously, m_ready_x=1 -> with VEC_TX_LOOP_EN, 16 back-to-back transfers and vec_count=2; without it, one idle cycle between the vectors.
REQ-035 reset asserted at ld_idx=5 -> state LOAD and ld_idx=0; the next 8 loads fill the buffer from index 0.

Source files
------------

// File: rtl/vec_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_stream_tx : loads a LENX-sample signed vector, then streams it on a   |
// | valid/ready port. Optional macro VEC_TX_LOOP_EN enables gapless re-send.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vec_stream_tx #(
  parameter int WIDTH  = 8,
  parameter int LENX   = 8,
  parameter int LOGLEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             start,
  input  logic             clr,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  output logic             busy,
  output logic [7:0]       vec_count
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [LOGLEN-1:0] c_last_idx = LOGLEN'(LENX - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [LOGLEN-1:0] r_ld_idx;
  logic [LOGLEN-1:0] r_tx_idx;
  logic [7:0]        r_vec_count;
  logic [WIDTH-1:0]  r_buf [LENX];

  logic w_ld_xfer;
  logic w_tx_xfer;
  logic w_ld_last;
  logic w_tx_last;
  logic w_start_send;

  assign w_ld_xfer    = (r_state == S_LOAD) && ld_valid;
  assign w_tx_xfer    = (r_state == S_SEND) && m_ready_x;
  assign w_ld_last    = (r_ld_idx == c_last_idx);
  assign w_tx_last    = (r_tx_idx == c_last_idx);
  assign w_start_send = (r_state == S_FULL) && start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: if (w_ld_xfer && w_ld_last) w_state_next = S_FULL;
      S_FULL: if (start) w_state_next = S_SEND;
      S_SEND: begin
        if (w_tx_xfer && w_tx_last) begin
`ifdef VEC_TX_LOOP_EN
          w_state_next = start ? S_SEND : S_FULL;
`else
          w_state_next = S_FULL;
`endif
        end
      end
      default: w_state_next = S_LOAD;
    endcase
    if (clr) w_state_next = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_ld_idx    <= '0;
      r_tx_idx    <= '0;
      r_vec_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (clr) begin
        r_ld_idx <= '0;
        r_tx_idx <= '0;
      end else begin
        if (w_ld_xfer) r_ld_idx <= w_ld_last ? '0 : r_ld_idx + 1'b1;
        if (w_start_send) r_tx_idx <= '0;
        if (w_tx_xfer) begin
          r_tx_idx <= w_tx_last ? '0 : r_tx_idx + 1'b1;
          if (w_tx_last) r_vec_count <= r_vec_count + 8'd1;
        end
      end
    end
  end

  // Buffer is deliberately not reset; only the index bookkeeping matters.
  always_ff @(posedge clk) begin
    if (!reset && !clr && w_ld_xfer) r_buf[r_ld_idx] <= ld_data;
  end

  assign ld_ready     = (r_state == S_LOAD);
  assign m_valid_x    = (r_state == S_SEND);
  assign m_data_out_x = (r_state == S_SEND) ? r_buf[r_tx_idx] : '0;
  assign busy         = (r_state == S_SEND);
  assign vec_count    = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_vec_stream_tx.sv
`default_nettype none
// Self-checking bench for vec_stream_tx: directed and random vectors compared
// against an expected-sample model held in plain arrays.
module tb_vec_stream_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ld_data = 8'd0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] m_data_out_x;
  logic       m_valid_x;
  logic       m_ready_x = 1'b0;
  logic       busy;
  logic [7:0] vec_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_count = 0;
  logic [7:0] model_vec [8];

  vec_stream_tx #(.WIDTH(8), .LENX(8), .LOGLEN(3)) dut (
    .clk(clk), .reset(reset), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .start(start), .clr(clr),
    .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
    .busy(busy), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec;
    ld_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ld_ready_load", 32'(ld_ready), 32'd1);
      ld_data = model_vec[i];
      tick();
    end
    ld_valid = 1'b0;
    check("ld_ready_full", 32'(ld_ready), 32'd0);
    check("valid_full", 32'(m_valid_x), 32'd0);
  endtask

  // Stream the model vector, optionally stalling stall_len cycles at sample stall_at.
  task automatic send_vec(input int stall_at, input int stall_len);
    start = 1'b1;
    m_ready_x = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        m_ready_x = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          check("stall_valid", 32'(m_valid_x), 32'd1);
          check("stall_data", 32'(m_data_out_x), 32'(model_vec[i]));
          tick();
        end
        m_ready_x = 1'b1;
      end
      check("tx_valid", 32'(m_valid_x), 32'd1);
      check("tx_data", 32'(m_data_out_x), 32'(model_vec[i]));
      check("tx_busy", 32'(busy), 32'd1);
      tick();
    end
    exp_count = (exp_count + 1) % 256;
    check("end_valid", 32'(m_valid_x), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("vec_count", 32'(vec_count), 32'(exp_count));
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_valid", 32'(m_valid_x), 32'd0);
    check("rst_data", 32'(m_data_out_x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(vec_count), 32'd0);

    // Basic 1..8 vector
    for (int i = 0; i < 8; i++) model_vec[i] = 8'(i + 1);
    load_vec();
    send_vec(-1, 0);

    // Loads ignored in FULL, then backpressure at index 2 for 3 cycles
    ld_valid = 1'b1; ld_data = 8'hAA;
    tick(); tick();
    ld_valid = 1'b0;
    send_vec(2, 3);

    // Signed extremes, re-sent twice
    clr = 1'b1; tick(); clr = 1'b0;
    model_vec[0] = -8'sd5;  model_vec[1] = 8'sd7;  model_vec[2] = 8'sd0;
    model_vec[3] = 8'h80;   model_vec[4] = 8'sd127; model_vec[5] = 8'sd1;
    model_vec[6] = -8'sd1;  model_vec[7] = 8'sd2;
    load_vec();
    send_vec(-1, 0);
    send_vec(-1, 0);

    // Random vectors with random stalls
    for (int r = 0; r < 4; r++) begin
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 0; i < 8; i++) model_vec[i] = 8'($urandom);
      load_vec();
      send_vec(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
    end

    // clr together with a transfer at tx_idx 4
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 8; i++) model_vec[i] = 8'($urandom);
    load_vec();
    start = 1'b1; m_ready_x = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_clr_data", 32'(m_data_out_x), 32'(model_vec[4]));
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_valid", 32'(m_valid_x), 32'd0);
    check("clr_ld_ready", 32'(ld_ready), 32'd1);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_count", 32'(vec_count), 32'(exp_count));

    // start held continuously
    for (int i = 0; i < 8; i++) model_vec[i] = 8'($urandom);
    load_vec();
    start = 1'b1; m_ready_x = 1'b1; tick();
`ifdef VEC_TX_LOOP_EN
    for (int c = 0; c < 16; c++) begin
      check("loop_valid", 32'(m_valid_x), 32'd1);
      check("loop_data", 32'(m_data_out_x), 32'(model_vec[c % 8]));
      tick();
    end
`else
    for (int c = 0; c < 17; c++) begin
      if (c == 8) begin
        check("gap_valid", 32'(m_valid_x), 32'd0);
      end else begin
        check("hold_valid", 32'(m_valid_x), 32'd1);
        check("hold_data", 32'(m_data_out_x), 32'(model_vec[(c > 8 ? c - 1 : c) % 8]));
      end
      tick();
    end
`endif
    start = 1'b0;
    exp_count = (exp_count + 2) % 256;
    check("loop_count", 32'(vec_count), 32'(exp_count));
    clr = 1'b1; tick(); clr = 1'b0;

    // reset part-way through loading
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_data = 8'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_count = 0;
    check("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    check("mid_rst_count", 32'(vec_count), 32'd0);
    for (int i = 0; i < 8; i++) model_vec[i] = 8'($urandom);
    load_vec();
    send_vec(-1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
